// File: rtl/cic_decim_iq.sv
// cic_decim_iq: dual-channel (I/Q) CIC decimator, runtime power-of-two rate, shared comb datapath.
// Optional round-half-up with positive saturation when CIC_DECIM_IQ_ROUND_EN is defined.
module cic_decim_iq #(
  parameter int IN_W          = 8,
  parameter int OUT_W         = 16,
  parameter int STAGES        = 3,
  parameter int RATE_LOG2_MAX = 6
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic                    in_tick,
  input  logic signed [IN_W-1:0]  in_I,
  input  logic signed [IN_W-1:0]  in_Q,
  input  logic        [2:0]       rate_sel,
  output logic signed [OUT_W-1:0] out_I,
  output logic signed [OUT_W-1:0] out_Q,
  output logic                    out_tick,
  output logic                    overrun
);

  localparam int ACC_W   = IN_W + STAGES * RATE_LOG2_MAX;
  localparam int GAIN_SH = OUT_W - IN_W;
  localparam int SH_W    = ACC_W + GAIN_SH + 1;
  localparam int CNT_W   = RATE_LOG2_MAX + 1;
  localparam int IDX_W   = $clog2(2 * STAGES + 1);

  typedef enum logic [1:0] {IDLE, COMB, SCALE, OUT} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              rate_act, rate_req;
  logic                    rate_chg;
  logic [CNT_W-1:0]        cnt, cnt_last;
  logic                    snap_evt, accept;
  logic [IDX_W-1:0]        idx, stage;
  logic                    comb_q_sel;

  logic signed [ACC_W-1:0] integ_i     [STAGES];
  logic signed [ACC_W-1:0] integ_q     [STAGES];
  logic signed [ACC_W-1:0] integ_i_nxt [STAGES];
  logic signed [ACC_W-1:0] integ_q_nxt [STAGES];
  logic signed [ACC_W-1:0] dly_i       [STAGES];
  logic signed [ACC_W-1:0] dly_q       [STAGES];

  logic signed [ACC_W-1:0] snap_i_p0, snap_q_p0;
  logic signed [ACC_W-1:0] work_p1, res_i_p1, res_q_p1;
  logic signed [ACC_W-1:0] comb_x, comb_d, comb_y;
  logic signed [OUT_W-1:0] scl_i_p2, scl_q_p2;

  // Gain normalisation: lift to OUT_W scale, then divide by R^STAGES = 2^(STAGES*rate).
  function automatic logic signed [OUT_W-1:0] scale(input logic signed [ACC_W-1:0] x,
                                                     input logic [2:0] r);
    logic signed [SH_W-1:0] v;
    int sh;
`ifdef CIC_DECIM_IQ_ROUND_EN
    logic signed [SH_W-1:0] lim;
`endif
    sh = STAGES * int'(r);
    v  = SH_W'(x);
    v  = v <<< GAIN_SH;
`ifdef CIC_DECIM_IQ_ROUND_EN
    if (sh > 0) v = v + (SH_W'(1) <<< (sh - 1));
    v   = v >>> sh;
    lim = '0;
    lim[OUT_W-2:0] = '1;
    if (v > lim) v = lim;
`else
    v = v >>> sh;
`endif
    return v[OUT_W-1:0];
  endfunction

  always_comb begin
    rate_req = rate_sel;
    if (int'(rate_sel) > RATE_LOG2_MAX) rate_req = 3'(RATE_LOG2_MAX);
  end

  assign rate_chg = (rate_req != rate_act);
  assign cnt_last = (CNT_W'(1) << rate_act) - CNT_W'(1);
  assign snap_evt = in_tick && !rate_chg && (cnt == cnt_last);
  assign accept   = snap_evt && (state_q == IDLE);

  // Integrators chain within one cycle; wrap-around is relied upon, never saturated.
  always_comb begin : integ_next
    logic signed [ACC_W-1:0] acc_i, acc_q;
    acc_i = ACC_W'(in_I);
    acc_q = ACC_W'(in_Q);
    for (int k = 0; k < STAGES; k++) begin
      acc_i          = integ_i[k] + acc_i;
      acc_q          = integ_q[k] + acc_q;
      integ_i_nxt[k] = acc_i;
      integ_q_nxt[k] = acc_q;
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_i[k] <= '0;
        integ_q[k] <= '0;
      end
    end else if (rate_chg) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_i[k] <= '0;
        integ_q[k] <= '0;
      end
    end else if (in_tick) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_i[k] <= integ_i_nxt[k];
        integ_q[k] <= integ_q_nxt[k];
      end
    end
  end

  // Stage 0: decimation counter and snapshot of the last integrator (includes this tick).
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      rate_act  <= '0;
      cnt       <= '0;
      snap_i_p0 <= '0;
      snap_q_p0 <= '0;
    end else if (rate_chg) begin
      rate_act  <= rate_req;
      cnt       <= '0;
      snap_i_p0 <= '0;
      snap_q_p0 <= '0;
    end else if (in_tick) begin
      cnt <= (cnt == cnt_last) ? '0 : cnt + CNT_W'(1);
      if (accept) begin
        snap_i_p0 <= integ_i_nxt[STAGES-1];
        snap_q_p0 <= integ_q_nxt[STAGES-1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = COMB;
      COMB:    if (idx == IDX_W'(2 * STAGES - 1)) state_d = SCALE;
      SCALE:   state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rate_chg) state_d = IDLE;
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= IDLE;
      idx     <= '0;
    end else begin
      state_q <= state_d;
      idx     <= (rate_chg || state_q != COMB) ? '0 : idx + IDX_W'(1);
    end
  end

  // Stage 1: one shared subtractor walks I stages then Q stages.
  always_comb begin
    comb_q_sel = (idx >= IDX_W'(STAGES));
    stage      = comb_q_sel ? idx - IDX_W'(STAGES) : idx;
    comb_x     = work_p1;
    if (stage == '0) comb_x = comb_q_sel ? snap_q_p0 : snap_i_p0;
    comb_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (stage == IDX_W'(k)) comb_d = comb_q_sel ? dly_q[k] : dly_i[k];
    end
    comb_y = comb_x - comb_d;
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      for (int k = 0; k < STAGES; k++) begin
        dly_i[k] <= '0;
        dly_q[k] <= '0;
      end
    end else if (rate_chg) begin
      for (int k = 0; k < STAGES; k++) begin
        dly_i[k] <= '0;
        dly_q[k] <= '0;
      end
    end else if (state_q == COMB) begin
      for (int k = 0; k < STAGES; k++) begin
        if (stage == IDX_W'(k)) begin
          if (comb_q_sel) dly_q[k] <= comb_x;
          else            dly_i[k] <= comb_x;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (state_q == COMB) begin
      work_p1 <= comb_y;
      if (idx == IDX_W'(STAGES - 1))     res_i_p1 <= comb_y;
      if (idx == IDX_W'(2 * STAGES - 1)) res_q_p1 <= comb_y;
    end
    // Stage 2: normalise both channels together.
    if (state_q == SCALE) begin
      scl_i_p2 <= scale(res_i_p1, rate_act);
      scl_q_p2 <= scale(res_q_p1, rate_act);
    end
  end

  // Stage 3: publish; a rate change in this cycle suppresses the aborted sample.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      out_I    <= '0;
      out_Q    <= '0;
      out_tick <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      out_tick <= 1'b0;
      if (snap_evt && state_q != IDLE) overrun <= 1'b1;
      if (state_q == OUT && !rate_chg) begin
        out_tick <= 1'b1;
        out_I    <= scl_i_p2;
        out_Q    <= scl_q_p2;
      end
    end
  end

endmodule

// File: doc/cic_decim_iq.md
Name: cic_decim_iq

Overview:
- Parametrised dual-channel (I/Q) CIC decimator; successor to the fixed single-channel CIC in the AM receiver chain.
- Sits between the 2-bit mixer outputs and the AM demodulator; replaces the cascaded single-channel CIC pairs.
- Configurable order, widths and maximum rate; decimation is runtime-selectable as a power of two.
- I and Q use separate integrators and one time-multiplexed comb datapath sequenced by an FSM; output is gain-normalised.

Parameters:
- IN_W, 8, input sample width, signed two's complement.
- OUT_W, 16, output sample width, signed; OUT_W >= IN_W.
- STAGES, 3, CIC order N (integrator and comb count per channel), 1..6.
- RATE_LOG2_MAX, 6, maximum log2 of decimation; ACC_W = IN_W + STAGES*RATE_LOG2_MAX.

Ports:
- CLK  in  1  system clock.
- RSTb  in  1  reset; asynchronous assert, active-low.
- in_tick  in  1  input sample strobe; in_I/in_Q valid while high.
- in_I  in  IN_W  I input sample.
- in_Q  in  IN_W  Q input sample.
- rate_sel  in  3  log2 of decimation R; values > RATE_LOG2_MAX clamp to RATE_LOG2_MAX.
- out_I  out  OUT_W  decimated I output; holds between ticks.
- out_Q  out  OUT_W  decimated Q output; holds between ticks.
- out_tick  out  1  one-cycle strobe; new out_I/out_Q valid.
- overrun  out  1  sticky; a decimated snapshot was dropped.

Behaviour:
- Reset (RSTb low, asynchronous): all integrators, comb delay regs, decimation counter, FSM = IDLE, out_I, out_Q, out_tick, overrun = 0; active rate latched from rate_sel on first clock after release.
- Integrators: on each in_tick, each channel's STAGES integrators update in one cycle. Sign-extend to ACC_W, wrap-around two's complement. Overflow is intentional and must not saturate.
- Decimation counter: counts in_tick 0..R-1, R = 2^rate_act. On the tick where count = R-1, register both last-stage integrator values into snapshot regs next edge (edge 0) and wrap to 0.
- FSM states:
  - IDLE: wait for snapshot.
  - COMB: one comb stage per clock; I stages 0..STAGES-1, then Q stages 0..STAGES-1 (2*STAGES cycles). Each stage computes y = x - d and updates d <= x, ACC_W wrap.
  - SCALE: 1 cycle, both channels.
  - OUT: 1 cycle, out_tick = 1 and outputs updated, then IDLE.
- Latency: out_tick high in the cycle after edge 2*STAGES+2, counted from the edge sampling the R-th in_tick.
- Scaling: v = comb_out << (OUT_W-IN_W), arithmetic right shift by STAGES*rate_act (floor), take the low OUT_W bits. DC input x settles to x*2^(OUT_W-IN_W).
- Settling: outputs from the (STAGES+1)-th out_tick after reset or a rate change are exact for DC input.
- Overrun: a snapshot event while FSM != IDLE discards that snapshot; comb delays are untouched and overrun is set. overrun clears only on reset. Minimum safe in_tick spacing at R=1 is 2*STAGES+3 clocks.
- Rate change: rate_sel compared to rate_act every clock. On mismatch, the next edge synchronously clears integrators, combs, counter and snapshot, aborts the FSM to IDLE (no out_tick for the aborted sample), and loads rate_act. out_I/out_Q hold their last values. An in_tick in that same cycle is ignored.
- Simultaneous in_tick and OUT state: integrate normally; independent paths.
- Reset asserted mid-COMB: immediate return to reset values; no partial out_tick.

Optional Feature:
- Macro CIC_DECIM_IQ_ROUND_EN.
- Defined: before the right shift, add 2^(shift-1) when shift > 0 (round half up). If the rounded result exceeds the OUT_W max positive, saturate to 2^(OUT_W-1)-1. Adds no latency.
- Undefined: floor truncation only, no saturation logic.

Test Plan:
- Reset/idle: RSTb low, then high, no in_tick for 1000 clocks -> out_tick never asserted; out_I = out_Q = 0, overrun = 0.
- DC gain: STAGES=3, rate_sel=3, in_I = 16, in_Q = -16, in_tick every 16 clocks -> from the 4th out_tick, out_I = 4096, out_Q = -4096; out_tick exactly every 8 in_ticks, 8 clocks after the 8th tick's edge.
- Rate switch: DC in_I = 100 at rate_sel=2, then rate_sel changed to 5 -> no out_tick for the aborted sample; outputs hold 25600 until new data, and settle again to 25600 after 4 new out_ticks at R=32.
- Overrun: rate_sel=0, in_tick every clock -> overrun = 1 within 2 clocks of the second tick; it stays 1 after in_tick stops; out_tick still pulses for accepted snapshots.
- Wrap-around: in_I = -128 for 4096 ticks at rate_sel=6 -> integrators wrap, out_I settles to -32768 with no glitch. With ROUND_EN, in_I = 127 at rate_sel=1 gives 32512.
- Mixer-chain: feed mix0-style 2-bit I/Q from the 936 kHz NCO, rate_sel=6 -> out_I/out_Q match the cascaded single-channel reference model bit-exactly, up to normalisation shift.
